sample_mem_arbiter: RTL and testbench

- Shares the single-port sample RAM (102400 words) between two requesters:
  - the acquisition write path (memory controller fed by the ADC);
  - the host read path (HPS bridge reading captured frames).
- Write has priority during acquisition, with a read-starvation guard.
- When the acquisition side completes a triggered frame, the block freezes the memory so the host can read a consistent frame, then hands it back on release.

---
 rtl/sample_mem_pkg.sv | 13 +
 rtl/sample_mem_arbiter_rd_valid_pipe.sv | 47 ++++
 rtl/sample_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_sample_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_mem_pkg.sv
// Shared types and constants for the sample RAM arbiter.
// Used by the arbiter top and its read-return pipeline.
package sample_mem_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } arb_state_t;

  localparam int MEM_DEPTH_C = 102400;
  localparam int ADDR_W_C    = 17;

endpackage

// File: rtl/sample_mem_arbiter_rd_valid_pipe.sv
// Read-return delay line: tracks accepted reads for RD_LAT cycles and
// presents RAM data (or zero for out-of-range reads) with rd_valid.
module rd_valid_pipe #(
  parameter int RD_LAT = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] valid_sr;
  logic [RD_LAT-1:0] zero_sr;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_sr <= '0;
      zero_sr  <= '0;
      data_q   <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      zero_sr[0]  <= in_zero;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        zero_sr[i]  <= zero_sr[i-1];
      end
      if (out_valid) begin
        data_q <= out_data;
      end
    end
  end

  // Data passes straight through on the return cycle, then is held.
  always_comb begin
    out_valid = valid_sr[RD_LAT-1];
    out_data  = data_q;
    if (out_valid) begin
      out_data = zero_sr[RD_LAT-1] ? '0 : ram_rdata;
    end
  end

endmodule

// File: rtl/sample_mem_arbiter.sv
// Single-port sample RAM arbiter: acquisition writes win with a read
// starvation guard; a completed frame is frozen for host reads.
module sample_mem_arbiter
  import sample_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_C,
  parameter int DATA_W     = 16,
  parameter int MEM_DEPTH  = MEM_DEPTH_C,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              frame_done,
  input  logic              frame_release,
  output logic              frame_locked,
  output logic              frame_overrun,
  output logic              addr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W:0]  DEPTH_L    = (ADDR_W + 1)'(MEM_DEPTH);

  arb_state_t       state;
  arb_state_t       next_state;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             wr_grant;
  logic             rd_grant;
  logic             wr_in_range;
  logic             rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

  // Grants are held off while reset is asserted so every output idles at zero.
  always_comb begin
    wr_grant   = 1'b0;
    rd_grant   = 1'b0;
    next_state = state;
    starve_nxt = '0;
    case (state)
      ACQUIRE: begin
        if (reset_n) begin
          if (wr_req && !(rd_req && starve_cnt == STARVE_LIM)) begin
            wr_grant = 1'b1;
          end else if (rd_req) begin
            rd_grant = 1'b1;
          end
        end
        if (rd_req && !rd_grant) begin
          starve_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
        end
        if (frame_done) begin
          next_state = LOCKED;
        end
      end
      LOCKED: begin
        rd_grant = reset_n && rd_req;
        if (frame_release) begin
          next_state = ACQUIRE;
        end
      end
      default: next_state = ACQUIRE;
    endcase
  end

  always_comb begin
    wr_ready     = wr_grant;
    rd_ready     = rd_grant;
    ram_we       = wr_grant && wr_in_range;
    ram_wdata    = wr_grant ? wr_data : '0;
    ram_addr     = '0;
    frame_locked = (state == LOCKED);
    if (wr_grant) begin
      ram_addr = wr_addr;
    end else if (rd_grant) begin
      ram_addr = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ACQUIRE;
      starve_cnt    <= '0;
      frame_overrun <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_nxt;
      // Release takes precedence over a coincident frame_done.
      if (state == LOCKED) begin
        if (frame_release) begin
          frame_overrun <= 1'b0;
        end else if (frame_done) begin
          frame_overrun <= 1'b1;
        end
      end
      if ((wr_grant && !wr_in_range) || (rd_grant && !rd_in_range)) begin
        addr_err <= 1'b1;
      end
    end
  end

  rd_valid_pipe #(
    .RD_LAT(RD_LAT),
    .DATA_W(DATA_W)
  ) u_rd_valid_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (rd_grant),
    .in_zero  (!rd_in_range),
    .ram_rdata(ram_rdata),
    .out_valid(rd_valid),
    .out_data (rd_data)
  );

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// Self-checking bench for sample_mem_arbiter: behavioural RAM, a read
// scoreboard keyed by due cycle, and directed arbitration/lock scenarios.
module tb_sample_mem_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 102400;
  localparam int RD_LAT = 2;
  localparam int STARVE = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_req, rd_req, frame_done, frame_release;
  logic [ADDR_W-1:0] wr_addr, rd_addr, ram_addr;
  logic [DATA_W-1:0] wr_data, rd_data, ram_wdata, ram_rdata;
  logic              wr_ready, rd_ready, rd_valid, ram_we;
  logic              frame_locked, frame_overrun, addr_err;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  rd_exp_t     exp_item;
  logic [15:0] model_mem [0:1023];
  logic [15:0] ram [0:1023];
  logic [9:0]  addr_pipe [0:RD_LAT-1];
  int          cyc = 0;
  int          check_count = 0;
  int          pass_count = 0;
  int          stall;
  bit          granted;

  sample_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH),
    .RD_LAT(RD_LAT), .STARVE_MAX(STARVE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .frame_done(frame_done), .frame_release(frame_release),
    .frame_locked(frame_locked), .frame_overrun(frame_overrun), .addr_err(addr_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM with RD_LAT cycles from address to data.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr[9:0]] <= ram_wdata;
    addr_pipe[0] <= ram_addr[9:0];
    for (int i = 1; i < RD_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign ram_rdata = ram[addr_pipe[RD_LAT-1]];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else pass_count++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Scoreboard: record expected data at accept time, compare on return.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        check_output("rd_valid_on_time", {31'b0, rd_valid}, 32'd1);
        void'(rd_q.pop_front());
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          check_output("rd_valid_unexpected", {31'b0, rd_valid}, 32'd0);
        end else begin
          exp_item = rd_q.pop_front();
          check_output("rd_valid_latency", cyc, exp_item.due);
          check_output("rd_data", {16'b0, rd_data}, {16'b0, exp_item.data});
        end
      end
      if (wr_req && wr_ready && int'(wr_addr) < DEPTH) model_mem[wr_addr[9:0]] = wr_data;
      if (rd_req && rd_ready)
        rd_q.push_back('{cyc + RD_LAT, (int'(rd_addr) < DEPTH) ? model_mem[rd_addr[9:0]] : 16'h0});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 16'h0;
      model_mem[i] = 16'h0;
    end
    for (int i = 0; i < RD_LAT; i++) addr_pipe[i] = '0;
    reset_n = 1'b0;
    wr_req = 0; rd_req = 0; frame_done = 0; frame_release = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_handshakes", {28'b0, wr_ready, rd_ready, rd_valid, ram_we}, 32'd0);
    check_output("reset_flags", {29'b0, frame_locked, frame_overrun, addr_err}, 32'd0);
    check_output("reset_ram_addr", {15'b0, ram_addr}, 32'd0);
    check_output("reset_data", {ram_wdata, rd_data}, 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // Plain writes in ACQUIRE
    for (int i = 0; i < 10; i++) begin
      wr_req = 1; wr_addr = ADDR_W'(i); wr_data = 16'h100 + 16'(i);
      @(negedge clk);
      check_output("wr_ready", {31'b0, wr_ready}, 32'd1);
      check_output("wr_ram_we", {31'b0, ram_we}, 32'd1);
      check_output("wr_ram_addr", {15'b0, ram_addr}, i);
      next_cycle();
    end
    wr_req = 0;

    // Contention: read forced through after STARVE stalled cycles
    wr_req = 1; wr_addr = 20; wr_data = 16'hAAAA;
    rd_req = 1; rd_addr = 5;
    stall = 0; granted = 0;
    for (int k = 0; k < 20 && !granted; k++) begin
      @(negedge clk);
      if (rd_ready) begin
        granted = 1;
        check_output("starve_wr_ready", {31'b0, wr_ready}, 32'd0);
        check_output("starve_ram_we", {31'b0, ram_we}, 32'd0);
        check_output("starve_ram_addr", {15'b0, ram_addr}, 32'd5);
      end else begin
        stall++;
      end
      next_cycle();
    end
    rd_req = 0;
    check_output("starve_granted", {31'b0, granted}, 32'd1);
    check_output("starve_stall_cycles", stall, STARVE);
    @(negedge clk);
    check_output("starve_wr_resumes", {31'b0, wr_ready}, 32'd1);
    next_cycle();
    wr_req = 0;
    idle(3);

    // Lock with a write pending
    wr_req = 1; wr_addr = 30; wr_data = 16'h1234; frame_done = 1;
    @(negedge clk);
    check_output("done_cycle_wr_ready", {31'b0, wr_ready}, 32'd1);
    check_output("done_cycle_unlocked", {31'b0, frame_locked}, 32'd0);
    next_cycle();
    frame_done = 0;
    @(negedge clk);
    check_output("locked", {31'b0, frame_locked}, 32'd1);
    check_output("locked_wr_stall", {30'b0, wr_ready, ram_we}, 32'd0);
    next_cycle();
    rd_req = 1;
    for (int j = 0; j < 4; j++) begin
      rd_addr = ADDR_W'(j);
      @(negedge clk);
      check_output("locked_rd_ready", {31'b0, rd_ready}, 32'd1);
      next_cycle();
    end
    rd_req = 0;
    idle(3);

    // Overrun, release, simultaneous done+release
    frame_done = 1;
    next_cycle();
    frame_done = 0;
    @(negedge clk);
    check_output("overrun_set", {30'b0, frame_locked, frame_overrun}, 32'd3);
    next_cycle();
    frame_release = 1;
    @(negedge clk);
    check_output("release_cycle_wr_stall", {31'b0, wr_ready}, 32'd0);
    next_cycle();
    frame_release = 0;
    @(negedge clk);
    check_output("released_flags", {30'b0, frame_locked, frame_overrun}, 32'd0);
    check_output("released_wr_granted", {31'b0, wr_ready}, 32'd1);
    next_cycle();
    frame_done = 1;
    next_cycle();
    frame_done = 0;
    @(negedge clk);
    check_output("relocked", {31'b0, frame_locked}, 32'd1);
    next_cycle();
    frame_done = 1; frame_release = 1;
    next_cycle();
    frame_done = 0; frame_release = 0;
    @(negedge clk);
    check_output("done_release_same_cycle", {30'b0, frame_locked, frame_overrun}, 32'd0);
    next_cycle();
    wr_req = 0;

    // Out-of-range addresses
    wr_req = 1; wr_addr = ADDR_W'(DEPTH); wr_data = 16'hDEAD;
    @(negedge clk);
    check_output("oor_wr_ready", {31'b0, wr_ready}, 32'd1);
    check_output("oor_ram_we", {31'b0, ram_we}, 32'd0);
    check_output("oor_addr_err_before", {31'b0, addr_err}, 32'd0);
    next_cycle();
    wr_req = 0;
    @(negedge clk);
    check_output("oor_addr_err", {31'b0, addr_err}, 32'd1);
    next_cycle();
    rd_req = 1; rd_addr = ADDR_W'(DEPTH + 1);
    @(negedge clk);
    check_output("oor_rd_ready", {31'b0, rd_ready}, 32'd1);
    next_cycle();
    rd_addr = 0;
    next_cycle();
    rd_req = 0;
    idle(4);

    // Reset one cycle after a read accept drops the read
    rd_req = 1; rd_addr = 1;
    @(negedge clk);
    check_output("pre_reset_rd_ready", {31'b0, rd_ready}, 32'd1);
    next_cycle();
    rd_req = 0;
    reset_n = 1'b0;
    rd_q.delete();
    @(negedge clk);
    check_output("midreset_outputs", {26'b0, wr_ready, rd_ready, rd_valid, ram_we, frame_locked, addr_err}, 32'd0);
    check_output("midreset_data", {rd_data, ram_addr[15:0]}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("post_reset_no_rd_valid", {31'b0, rd_valid}, 32'd0);
      next_cycle();
    end
    wr_req = 1; wr_addr = 2; wr_data = 16'h0202;
    @(negedge clk);
    check_output("post_reset_acquire", {29'b0, wr_ready, frame_locked, addr_err}, 32'd4);
    next_cycle();
    wr_req = 0;
    idle(2);

    check_output("scoreboard_drained", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
